// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared constants for the MIPS execute stage
//
// Purpose: ALU operation codes, R-type funct values, forwarding-mux codes,
//          multiply/divide sub-op codes and the mult/div iteration count.
// Ports:   none (package).

package ex_pkg;

  // Iterations per multiply/divide; one result bit per cycle for 32-bit operands.
  localparam int MD_CYCLES = 32;

  localparam logic [1:0] ALU_OP_ADD   = 2'b00;
  localparam logic [1:0] ALU_OP_SUB   = 2'b01;
  localparam logic [1:0] ALU_OP_RTYPE = 2'b10;
  localparam logic [1:0] ALU_OP_ADD2  = 2'b11;

  localparam logic [5:0] FUNCT_SLL   = 6'h00;
  localparam logic [5:0] FUNCT_SRL   = 6'h02;
  localparam logic [5:0] FUNCT_SRA   = 6'h03;
  localparam logic [5:0] FUNCT_MFHI  = 6'h10;
  localparam logic [5:0] FUNCT_MFLO  = 6'h12;
  localparam logic [5:0] FUNCT_MULT  = 6'h18;
  localparam logic [5:0] FUNCT_MULTU = 6'h19;
  localparam logic [5:0] FUNCT_DIV   = 6'h1A;
  localparam logic [5:0] FUNCT_DIVU  = 6'h1B;
  localparam logic [5:0] FUNCT_ADD   = 6'h20;
  localparam logic [5:0] FUNCT_ADDU  = 6'h21;
  localparam logic [5:0] FUNCT_SUB   = 6'h22;
  localparam logic [5:0] FUNCT_SUBU  = 6'h23;
  localparam logic [5:0] FUNCT_AND   = 6'h24;
  localparam logic [5:0] FUNCT_OR    = 6'h25;
  localparam logic [5:0] FUNCT_XOR   = 6'h26;
  localparam logic [5:0] FUNCT_NOR   = 6'h27;
  localparam logic [5:0] FUNCT_SLT   = 6'h2A;
  localparam logic [5:0] FUNCT_SLTU  = 6'h2B;

  localparam logic [1:0] FWD_REG   = 2'b00;
  localparam logic [1:0] FWD_WB    = 2'b01;
  localparam logic [1:0] FWD_EXMEM = 2'b10;

  // Sub-op handed to mul_div_unit is funct[1:0] of mult/multu/div/divu.
  localparam logic [1:0] MD_OP_MULT  = 2'b00;
  localparam logic [1:0] MD_OP_MULTU = 2'b01;
  localparam logic [1:0] MD_OP_DIV   = 2'b10;
  localparam logic [1:0] MD_OP_DIVU  = 2'b11;

  // funct 18..1B: the four instructions that launch the mult/div unit.
  function automatic logic is_md_start_funct(input logic [5:0] funct);
    return funct[5:2] == 4'b0110;
  endfunction

endpackage

// File: rtl/mul_div_unit.sv
// rtl/mul_div_unit.sv - iterative 32-cycle multiply/divide unit with HI/LO
//
// Purpose: shift-add multiply and restoring divide on operand magnitudes,
//          one bit per cycle, with sign fix-up applied when HI/LO are written.
// Ports:   clk, rst    - clock, synchronous active-high reset
//          start       - launch op on a/b this edge (ignored while busy)
//          op[1:0]     - 00 mult, 01 multu, 10 div, 11 divu
//          a, b        - rs / rt operands
//          busy        - iteration in progress
//          hi, lo      - architectural HI/LO registers

module mul_div_unit
  import ex_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int CNT_W = $clog2(MD_CYCLES);
  localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(MD_CYCLES - 1);

  // acc holds {partial product high, multiplier} for multiply and
  // {partial remainder, dividend/quotient} for divide.
  logic [63:0]      acc;
  logic [31:0]      opnd_b;
  logic             is_div;
  logic             neg_q;
  logic             neg_r;
  logic [CNT_W-1:0] count;

  logic        is_signed;
  logic        sign_a;
  logic        sign_b;
  logic [31:0] mag_a;
  logic [31:0] mag_b;

  logic [32:0] mul_sum;
  logic [64:0] div_shift;
  logic [32:0] div_diff;
  logic [63:0] acc_next;
  logic [63:0] prod_fixed;
  logic [31:0] res_hi;
  logic [31:0] res_lo;

  always_comb begin
    is_signed = ~op[0];
    sign_a    = is_signed & a[31];
    sign_b    = is_signed & b[31];
    mag_a     = sign_a ? (32'd0 - a) : a;
    mag_b     = sign_b ? (32'd0 - b) : b;
  end

  always_comb begin
    mul_sum   = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd_b} : 33'd0);
    div_shift = {acc, 1'b0};
    // Partial remainder is always below the divisor, so a non-borrowing
    // subtract leaves a result that fits in 32 bits.
    div_diff  = div_shift[64:32] - {1'b0, opnd_b};
    if (is_div) begin
      acc_next = div_diff[32] ? div_shift[63:0]
                              : {div_diff[31:0], div_shift[31:1], 1'b1};
    end else begin
      acc_next = {mul_sum, acc[31:1]};
    end

    prod_fixed = neg_q ? (64'd0 - acc_next) : acc_next;
    if (is_div) begin
      res_lo = neg_q ? (32'd0 - acc_next[31:0])  : acc_next[31:0];
      res_hi = neg_r ? (32'd0 - acc_next[63:32]) : acc_next[63:32];
    end else begin
      res_lo = prod_fixed[31:0];
      res_hi = prod_fixed[63:32];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      busy   <= 1'b0;
      count  <= '0;
      acc    <= '0;
      opnd_b <= '0;
      is_div <= 1'b0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else if (busy) begin
      acc   <= acc_next;
      count <= count + 1'b1;
      if (count == LAST_COUNT) begin
        busy  <= 1'b0;
        count <= '0;
        hi    <= res_hi;
        lo    <= res_lo;
      end
    end else if (start) begin
      busy   <= 1'b1;
      count  <= '0;
      acc    <= {32'd0, mag_a};
      opnd_b <= mag_b;
      is_div <= op[1];
      // Divide by zero keeps an unnegated all-ones quotient; the remainder
      // then reconstructs the original dividend through neg_r.
      neg_q  <= (sign_a ^ sign_b) & ~(op[1] & (b == 32'd0));
      neg_r  <= op[1] & sign_a;
    end
  end

endmodule

// File: rtl/ex_stage.sv
// rtl/ex_stage.sv - MIPS execute stage with EX/MEM register and mult/div
//
// Purpose: operand forwarding, ALU, branch target, destination select, the
//          EX/MEM pipeline register and an iterative HI/LO mult/div unit.
// Ports:   CLK, RST                 - clock, synchronous active-high reset
//          id_*                     - ID/EX register contents
//          forward_a/b, wb_data     - forwarding selects and WB value
//          flush                    - squash the instruction in EX
//          stall                    - hold IF/ID and ID/EX this cycle
//          md_busy                  - mult/div in progress
//          ex_*                     - registered EX/MEM outputs

module ex_stage
  import ex_pkg::*;
(
  input  logic        CLK,
  input  logic        RST,
  input  logic        id_valid,
  input  logic [1:0]  id_control_wb,
  input  logic        id_branch,
  input  logic        id_mem_read,
  input  logic        id_mem_write,
  input  logic        id_reg_dst,
  input  logic        id_alu_src,
  input  logic [1:0]  id_alu_op,
  input  logic [31:0] id_pc_plus4,
  input  logic [31:0] id_read_data1,
  input  logic [31:0] id_read_data2,
  input  logic [31:0] id_imm,
  input  logic [4:0]  id_rt,
  input  logic [4:0]  id_rd,
  input  logic [1:0]  forward_a,
  input  logic [1:0]  forward_b,
  input  logic [31:0] wb_data,
  input  logic        flush,
  output logic        stall,
  output logic        md_busy,
  output logic [1:0]  ex_control_wb,
  output logic        ex_branch,
  output logic        ex_mem_read,
  output logic        ex_mem_write,
  output logic        ex_alu_zero,
  output logic [31:0] ex_alu_result,
  output logic [31:0] ex_write_data,
  output logic [4:0]  ex_write_register,
  output logic [31:0] ex_branch_target
);

  logic [5:0]  funct;
  logic [4:0]  shamt;
  logic [31:0] op_a;
  logic [31:0] fwd_b;
  logic [31:0] op_b;
  logic [31:0] alu_result;
  logic        is_rtype;
  logic        md_class;
  logic        md_start;
  logic        bubble;
  logic [31:0] md_hi;
  logic [31:0] md_lo;

  assign funct = id_imm[5:0];
  assign shamt = id_imm[10:6];

  always_comb begin
    case (forward_a)
      FWD_WB:    op_a = wb_data;
      FWD_EXMEM: op_a = ex_alu_result;
      default:   op_a = id_read_data1;
    endcase
    case (forward_b)
      FWD_WB:    fwd_b = wb_data;
      FWD_EXMEM: fwd_b = ex_alu_result;
      default:   fwd_b = id_read_data2;
    endcase
    op_b = id_alu_src ? id_imm : fwd_b;
  end

  always_comb begin
    alu_result = '0;
    case (id_alu_op)
      ALU_OP_SUB:   alu_result = op_a - op_b;
      ALU_OP_RTYPE: begin
        case (funct)
          FUNCT_ADD, FUNCT_ADDU: alu_result = op_a + op_b;
          FUNCT_SUB, FUNCT_SUBU: alu_result = op_a - op_b;
          FUNCT_AND:  alu_result = op_a & op_b;
          FUNCT_OR:   alu_result = op_a | op_b;
          FUNCT_XOR:  alu_result = op_a ^ op_b;
          FUNCT_NOR:  alu_result = ~(op_a | op_b);
          FUNCT_SLT:  alu_result = {31'd0, $signed(op_a) < $signed(op_b)};
          FUNCT_SLTU: alu_result = {31'd0, op_a < op_b};
          FUNCT_SLL:  alu_result = op_b << shamt;
          FUNCT_SRL:  alu_result = op_b >> shamt;
          FUNCT_SRA:  alu_result = $signed(op_b) >>> shamt;
          FUNCT_MFHI: alu_result = md_hi;
          FUNCT_MFLO: alu_result = md_lo;
          default:    alu_result = '0;
        endcase
      end
      default:      alu_result = op_a + op_b;
    endcase
  end

  // A flushed md-class instruction is dead: it neither stalls nor launches.
  always_comb begin
    is_rtype = id_valid && (id_alu_op == ALU_OP_RTYPE);
    md_class = is_rtype && (funct == FUNCT_MFHI || funct == FUNCT_MFLO ||
                            is_md_start_funct(funct));
    stall    = md_busy && md_class && !flush;
    md_start = is_rtype && is_md_start_funct(funct) && !stall && !flush;
    bubble   = !id_valid || flush || stall;
  end

  mul_div_unit u_mul_div (
    .clk   (CLK),
    .rst   (RST),
    .start (md_start),
    .op    (funct[1:0]),
    .a     (op_a),
    .b     (fwd_b),
    .busy  (md_busy),
    .hi    (md_hi),
    .lo    (md_lo)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      ex_control_wb     <= '0;
      ex_branch         <= 1'b0;
      ex_mem_read       <= 1'b0;
      ex_mem_write      <= 1'b0;
      ex_alu_zero       <= 1'b0;
      ex_alu_result     <= '0;
      ex_write_data     <= '0;
      ex_write_register <= '0;
      ex_branch_target  <= '0;
    end else begin
      // Bubbles only need the side-effecting controls cleared; data fields
      // still load so the datapath stays free of extra enables.
      ex_control_wb     <= bubble ? 2'b00 : id_control_wb;
      ex_branch         <= bubble ? 1'b0  : id_branch;
      ex_mem_read       <= bubble ? 1'b0  : id_mem_read;
      ex_mem_write      <= bubble ? 1'b0  : id_mem_write;
      ex_alu_zero       <= (alu_result == 32'd0);
      ex_alu_result     <= alu_result;
      ex_write_data     <= fwd_b;
      ex_write_register <= id_reg_dst ? id_rd : id_rt;
      ex_branch_target  <= id_pc_plus4 + {id_imm[29:0], 2'b00};
    end
  end

endmodule

// File: tb/tb_ex_stage.sv
// tb/tb_ex_stage.sv - directed self-checking bench for ex_stage

module tb_ex_stage;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03;
  localparam logic [5:0] F_MFHI = 6'h10, F_MFLO = 6'h12;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1A, F_DIVU = 6'h1B;
  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A, F_SLTU = 6'h2B;

  logic        CLK = 1'b0;
  logic        RST;
  logic        id_valid;
  logic [1:0]  id_control_wb;
  logic        id_branch, id_mem_read, id_mem_write, id_reg_dst, id_alu_src;
  logic [1:0]  id_alu_op;
  logic [31:0] id_pc_plus4, id_read_data1, id_read_data2, id_imm;
  logic [4:0]  id_rt, id_rd;
  logic [1:0]  forward_a, forward_b;
  logic [31:0] wb_data;
  logic        flush;
  logic        stall, md_busy;
  logic [1:0]  ex_control_wb;
  logic        ex_branch, ex_mem_read, ex_mem_write, ex_alu_zero;
  logic [31:0] ex_alu_result, ex_write_data, ex_branch_target;
  logic [4:0]  ex_write_register;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  ex_stage dut (
    .CLK(CLK), .RST(RST), .id_valid(id_valid), .id_control_wb(id_control_wb),
    .id_branch(id_branch), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .id_reg_dst(id_reg_dst), .id_alu_src(id_alu_src), .id_alu_op(id_alu_op),
    .id_pc_plus4(id_pc_plus4), .id_read_data1(id_read_data1),
    .id_read_data2(id_read_data2), .id_imm(id_imm), .id_rt(id_rt), .id_rd(id_rd),
    .forward_a(forward_a), .forward_b(forward_b), .wb_data(wb_data), .flush(flush),
    .stall(stall), .md_busy(md_busy), .ex_control_wb(ex_control_wb),
    .ex_branch(ex_branch), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_alu_zero(ex_alu_zero), .ex_alu_result(ex_alu_result),
    .ex_write_data(ex_write_data), .ex_write_register(ex_write_register),
    .ex_branch_target(ex_branch_target)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic idle();
    id_valid = 0; id_control_wb = 0; id_branch = 0; id_mem_read = 0;
    id_mem_write = 0; id_reg_dst = 0; id_alu_src = 0; id_alu_op = 2'b00;
    id_pc_plus4 = 0; id_read_data1 = 0; id_read_data2 = 0; id_imm = 0;
    id_rt = 0; id_rd = 0; forward_a = 0; forward_b = 0; wb_data = 0; flush = 0;
  endtask

  task automatic set_r(input logic [5:0] f, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] sh);
    idle();
    id_valid = 1; id_alu_op = 2'b10; id_reg_dst = 1; id_control_wb = 2'b10;
    id_read_data1 = a; id_read_data2 = b; id_imm = {21'd0, sh, f};
    id_rt = 5'd4; id_rd = 5'd9;
  endtask

  // Launches a mult/div, waits out the busy window and reads LO then HI.
  task automatic run_md(input string name, input logic [5:0] f,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp_lo, input logic [31:0] exp_hi);
    int n;
    set_r(f, a, b, 5'd0);
    tick();
    idle();
    n = 0;
    while (md_busy && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL %s_busy_cycles: got %0d expected 32", name, n);
    end
    set_r(F_MFLO, 0, 0, 5'd0);
    tick();
    checks++;
    if (ex_alu_result !== exp_lo) begin
      errors++;
      $display("FAIL %s_lo: got %h expected %h", name, ex_alu_result, exp_lo);
    end
    set_r(F_MFHI, 0, 0, 5'd0);
    tick();
    checks++;
    if (ex_alu_result !== exp_hi) begin
      errors++;
      $display("FAIL %s_hi: got %h expected %h", name, ex_alu_result, exp_hi);
    end
    idle();
  endtask

  task automatic test_reset();
    idle();
    RST = 1;
    tick();
    tick();
    RST = 0;
    checks++;
    if ({ex_control_wb, ex_branch, ex_mem_read, ex_mem_write, ex_alu_zero,
         ex_alu_result, ex_write_data, ex_write_register, ex_branch_target,
         md_busy, stall} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: got res=%h wd=%h bt=%h busy=%b stall=%b expected all 0",
               ex_alu_result, ex_write_data, ex_branch_target, md_busy, stall);
    end
  endtask

  task automatic test_add_branch();
    idle();
    id_valid = 1; id_alu_op = 2'b00; id_alu_src = 1; id_control_wb = 2'b10;
    id_read_data1 = 32'd7; id_read_data2 = 32'h55; id_imm = 32'hFFFF_FFF9;
    id_pc_plus4 = 32'h100; id_rt = 5'd3; id_rd = 5'd12; id_branch = 1;
    tick();
    checks++;
    if (ex_alu_result !== 32'd0 || ex_alu_zero !== 1'b1) begin
      errors++;
      $display("FAIL add_zero: got res=%h zero=%b expected 00000000/1", ex_alu_result, ex_alu_zero);
    end
    checks++;
    if (ex_branch_target !== 32'h0000_00E4) begin
      errors++;
      $display("FAIL branch_target: got %h expected 000000e4", ex_branch_target);
    end
    checks++;
    if (ex_write_register !== 5'd3 || ex_write_data !== 32'h55 || ex_branch !== 1'b1) begin
      errors++;
      $display("FAIL add_fields: got wr=%0d wd=%h br=%b expected 3/00000055/1",
               ex_write_register, ex_write_data, ex_branch);
    end
    id_alu_op = 2'b01; id_imm = 32'd9;
    tick();
    checks++;
    if (ex_alu_result !== 32'hFFFF_FFFE || ex_alu_zero !== 1'b0) begin
      errors++;
      $display("FAIL sub_imm: got %h expected fffffffe", ex_alu_result);
    end
    idle();
  endtask

  task automatic test_rtype();
    logic [5:0]  f [12];
    logic [31:0] a [12];
    logic [31:0] b [12];
    logic [4:0]  s [12];
    logic [31:0] e [12];
    f[0]  = F_SUB;  a[0]  = 32'd5;          b[0]  = 32'd7;          s[0]  = 0; e[0]  = 32'hFFFF_FFFE;
    f[1]  = F_AND;  a[1]  = 32'hF0F0_00FF;  b[1]  = 32'h0FF0_0F0F;  s[1]  = 0; e[1]  = 32'h00F0_000F;
    f[2]  = F_OR;   a[2]  = 32'hF0F0_00FF;  b[2]  = 32'h0FF0_0F0F;  s[2]  = 0; e[2]  = 32'hFFF0_0FFF;
    f[3]  = F_XOR;  a[3]  = 32'hF0F0_00FF;  b[3]  = 32'h0FF0_0F0F;  s[3]  = 0; e[3]  = 32'hFF00_0FF0;
    f[4]  = F_NOR;  a[4]  = 32'hF0F0_00FF;  b[4]  = 32'h0FF0_0F0F;  s[4]  = 0; e[4]  = 32'h000F_F000;
    f[5]  = F_SLT;  a[5]  = 32'hFFFF_FFFF;  b[5]  = 32'd1;          s[5]  = 0; e[5]  = 32'd1;
    f[6]  = F_SLTU; a[6]  = 32'hFFFF_FFFF;  b[6]  = 32'd1;          s[6]  = 0; e[6]  = 32'd0;
    f[7]  = F_SLL;  a[7]  = 32'd0;          b[7]  = 32'h0000_00F1;  s[7]  = 4; e[7]  = 32'h0000_0F10;
    f[8]  = F_SRL;  a[8]  = 32'd0;          b[8]  = 32'h8000_0000;  s[8]  = 4; e[8]  = 32'h0800_0000;
    f[9]  = F_SRA;  a[9]  = 32'd0;          b[9]  = 32'h8000_0000;  s[9]  = 4; e[9]  = 32'hF800_0000;
    f[10] = 6'h3F;  a[10] = 32'd1;          b[10] = 32'd2;          s[10] = 0; e[10] = 32'd0;
    f[11] = F_ADDU; a[11] = 32'hFFFF_FFFF;  b[11] = 32'd2;          s[11] = 0; e[11] = 32'd1;
    for (int i = 0; i < 12; i++) begin
      set_r(f[i], a[i], b[i], s[i]);
      tick();
      checks++;
      if (ex_alu_result !== e[i] || ex_write_register !== 5'd9) begin
        errors++;
        $display("FAIL rtype_%0d funct=%h: got %h wr=%0d expected %h wr=9",
                 i, f[i], ex_alu_result, ex_write_register, e[i]);
      end
    end
    idle();
  endtask

  task automatic test_forward();
    idle();
    id_valid = 1; id_alu_op = 2'b00; id_alu_src = 1; id_imm = 32'd5;
    tick();
    set_r(F_ADD, 32'h999, 32'd3, 5'd0);
    forward_a = 2'b10;
    tick();
    checks++;
    if (ex_alu_result !== 32'd8) begin
      errors++;
      $display("FAIL fwd_exmem_a: got %h expected 00000008", ex_alu_result);
    end
    forward_a = 2'b01; wb_data = 32'd10;
    tick();
    checks++;
    if (ex_alu_result !== 32'd13) begin
      errors++;
      $display("FAIL fwd_wb_a: got %h expected 0000000d", ex_alu_result);
    end
    set_r(F_ADD, 32'd1, 32'd0, 5'd0);
    forward_b = 2'b10;
    tick();
    checks++;
    if (ex_alu_result !== 32'd14 || ex_write_data !== 32'd13) begin
      errors++;
      $display("FAIL fwd_exmem_b: got res=%h wd=%h expected 0000000e/0000000d",
               ex_alu_result, ex_write_data);
    end
    idle();
  endtask

  task automatic test_mult_stall();
    int n;
    int bad_bubbles;
    set_r(F_MULT, 32'hFFFF_FFFE, 32'd3, 5'd0);
    tick();
    checks++;
    if (md_busy !== 1'b1) begin
      errors++;
      $display("FAIL mult_start_busy: got %b expected 1", md_busy);
    end
    set_r(F_MFHI, 0, 0, 5'd0);
    #1;
    n = 0;
    bad_bubbles = 0;
    while (stall && n < 40) begin
      tick();
      n++;
      if (ex_control_wb !== 2'b00) bad_bubbles++;
    end
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL mult_stall_cycles: got %0d expected 32", n);
    end
    checks++;
    if (bad_bubbles !== 0) begin
      errors++;
      $display("FAIL stall_bubbles: got %0d non-bubble cycles expected 0", bad_bubbles);
    end
    tick();
    checks++;
    if (ex_alu_result !== 32'hFFFF_FFFF || ex_control_wb !== 2'b10) begin
      errors++;
      $display("FAIL mult_mfhi: got %h wb=%b expected ffffffff/10", ex_alu_result, ex_control_wb);
    end
    set_r(F_MFLO, 0, 0, 5'd0);
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++;
      $display("FAIL mflo_no_stall: got %b expected 0", stall);
    end
    tick();
    checks++;
    if (ex_alu_result !== 32'hFFFF_FFFA) begin
      errors++;
      $display("FAIL mult_mflo: got %h expected fffffffa", ex_alu_result);
    end
    idle();
  endtask

  task automatic test_independent_during_busy();
    int n;
    set_r(F_MULTU, 32'd5, 32'd6, 5'd0);
    tick();
    set_r(F_ADD, 32'd100, 32'd23, 5'd0);
    #1;
    checks++;
    if (stall !== 1'b0 || md_busy !== 1'b1) begin
      errors++;
      $display("FAIL indep_stall: got stall=%b busy=%b expected 0/1", stall, md_busy);
    end
    tick();
    checks++;
    if (ex_alu_result !== 32'd123 || ex_control_wb !== 2'b10) begin
      errors++;
      $display("FAIL indep_add: got %h wb=%b expected 0000007b/10", ex_alu_result, ex_control_wb);
    end
    idle();
    n = 1;
    while (md_busy && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (n !== 32) begin
      errors++;
      $display("FAIL indep_busy_cycles: got %0d expected 32", n);
    end
    set_r(F_MFLO, 0, 0, 5'd0);
    tick();
    checks++;
    if (ex_alu_result !== 32'd30) begin
      errors++;
      $display("FAIL multu_lo: got %h expected 0000001e", ex_alu_result);
    end
    idle();
  endtask

  task automatic test_divide();
    run_md("divu_by_zero", F_DIVU, 32'd7, 32'd0, 32'hFFFF_FFFF, 32'd7);
    run_md("div_neg", F_DIV, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 32'hFFFF_FFFF);
    run_md("div_ovf", F_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 32'd0);
  endtask

  task automatic test_reset_mid_md();
    set_r(F_MULT, 32'd3, 32'd4, 5'd0);
    tick();
    idle();
    repeat (9) tick();
    idle();
    id_valid = 1; id_alu_op = 2'b00; id_control_wb = 2'b11; id_branch = 1;
    id_mem_read = 1; id_mem_write = 1; id_read_data1 = 32'd1; id_read_data2 = 32'd2;
    id_pc_plus4 = 32'd4; id_imm = 32'd1; id_rt = 5'd7;
    RST = 1;
    tick();
    RST = 0;
    checks++;
    if (md_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_busy: got %b expected 0", md_busy);
    end
    checks++;
    if ({ex_control_wb, ex_branch, ex_mem_read, ex_mem_write, ex_alu_zero,
         ex_alu_result, ex_write_data, ex_write_register, ex_branch_target} !== '0) begin
      errors++;
      $display("FAIL rst_mid_outputs: got res=%h wd=%h bt=%h wb=%b expected all 0",
               ex_alu_result, ex_write_data, ex_branch_target, ex_control_wb);
    end
    set_r(F_MFLO, 0, 0, 5'd0);
    tick();
    checks++;
    if (ex_alu_result !== 32'd0 || ex_control_wb !== 2'b10 || md_busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mflo: got %h wb=%b busy=%b expected 00000000/10/0",
               ex_alu_result, ex_control_wb, md_busy);
    end
    set_r(F_MFHI, 0, 0, 5'd0);
    tick();
    checks++;
    if (ex_alu_result !== 32'd0) begin
      errors++;
      $display("FAIL rst_mfhi: got %h expected 00000000", ex_alu_result);
    end
    idle();
  endtask

  task automatic test_flush_bubble();
    set_r(F_MULT, 32'd2, 32'd3, 5'd0);
    flush = 1;
    tick();
    checks++;
    if (md_busy !== 1'b0 || ex_control_wb !== 2'b00) begin
      errors++;
      $display("FAIL flush_mult: got busy=%b wb=%b expected 0/00", md_busy, ex_control_wb);
    end
    idle();
    id_valid = 1; id_alu_op = 2'b00; id_alu_src = 1; id_mem_read = 1;
    id_control_wb = 2'b11; id_read_data1 = 32'd100; id_imm = 32'd4;
    flush = 1;
    tick();
    checks++;
    if (ex_mem_read !== 1'b0 || ex_control_wb !== 2'b00) begin
      errors++;
      $display("FAIL flush_lw: got mr=%b wb=%b expected 0/00", ex_mem_read, ex_control_wb);
    end
    flush = 0;
    tick();
    checks++;
    if (ex_mem_read !== 1'b1 || ex_control_wb !== 2'b11 || ex_alu_result !== 32'd104) begin
      errors++;
      $display("FAIL lw: got mr=%b wb=%b res=%h expected 1/11/00000068",
               ex_mem_read, ex_control_wb, ex_alu_result);
    end
    id_valid = 0;
    tick();
    checks++;
    if (ex_mem_read !== 1'b0 || ex_control_wb !== 2'b00) begin
      errors++;
      $display("FAIL invalid_bubble: got mr=%b wb=%b expected 0/00", ex_mem_read, ex_control_wb);
    end
    idle();
  endtask

  initial begin
    RST = 1;
    idle();
    test_reset();
    test_add_branch();
    test_rtype();
    test_forward();
    test_mult_stall();
    test_independent_during_busy();
    test_divide();
    test_reset_mid_md();
    test_flush_bubble();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
